interface_a_responder: RTL and testbench

- Responder end of the InterfaceA request channel.
- The initiator, through modport `a`, drives request words (`aa`) and samples `a` as its ready indication. This block consumes those words and owns the DEPTH x WIDTH register bank exposed as `aaa`.
- It executes single-beat reads and two-beat writes against the bank, and returns one response per transaction.

---
 rtl/interface_a_responder_if.sv | 11 +
 rtl/interface_a_responder.sv | 129 ++++++++++++
 tb/tb_interface_a_responder.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/interface_a_responder_if.sv
// InterfaceA request channel: the initiator drives valid/word (aa); the responder returns ready (a).
interface interface_a_responder_if #(
    parameter int WIDTH = 10
) ();
    logic             valid;
    logic [WIDTH-1:0] word;
    logic             ready;

    modport master (output valid, output word, input ready);
    modport slave  (input valid, input word, output ready);
endinterface

// File: rtl/interface_a_responder.sv
// Responder for the InterfaceA request channel: single-beat reads and two-beat writes
// against a DEPTH x WIDTH register bank, with one response pulse per transaction.
module interface_a_responder #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 10,
    parameter int CNTW  = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    interface_a_responder_if.slave i_bus,
    output logic                   o_rsp_valid,
    output logic [WIDTH-1:0]       o_rsp_data,
    output logic                   o_rsp_err,
    output logic [DEPTH*WIDTH-1:0] o_bank,
    output logic [CNTW-1:0]        o_txn_count
);
    localparam int IDXW = $clog2(DEPTH);

    generate
        if (WIDTH < IDXW + 1) begin : g_widthCheck
            $error("interface_a_responder: WIDTH must be at least IDXW+1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, WDATA, RESP} state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic             r_ready;
    logic             r_rspValid;
    logic [WIDTH-1:0] r_rspData;
    logic             r_rspErr;
    logic [IDXW-1:0]  r_idx;
    logic             r_idxErr;
    logic [CNTW-1:0]  r_txnCount;
    logic [WIDTH-1:0] r_bank [DEPTH];

    logic [IDXW-1:0]  w_idx;
    logic             w_idxErr;
    logic             w_isWrite;
    logic             w_accept;
    logic [WIDTH-1:0] w_rdData;

    assign w_idx     = i_bus.word[IDXW-1:0];
    assign w_isWrite = i_bus.word[WIDTH-1];
    assign w_idxErr  = ({1'b0, w_idx} >= (IDXW + 1)'(DEPTH));
    assign w_accept  = i_bus.valid && r_ready;

    // Row match by comparison so out-of-range indices read as zero and never alias a row
    always_comb begin
        w_rdData = '0;
        for (int r = 0; r < DEPTH; r++) begin
            if (w_idx == IDXW'(r)) begin
                w_rdData = r_bank[r];
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_nextState = w_isWrite ? WDATA : RESP;
            WDATA:   if (w_accept) w_nextState = RESP;
            RESP:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Ready and the response pulse are registered from the next state so both line up with RESP
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_ready    <= 1'b0;
            r_rspValid <= 1'b0;
            r_rspData  <= '0;
            r_rspErr   <= 1'b0;
            r_idx      <= '0;
            r_idxErr   <= 1'b0;
            r_txnCount <= '0;
            for (int r = 0; r < DEPTH; r++) begin
                r_bank[r] <= '0;
            end
        end else begin
            r_ready    <= (w_nextState != RESP);
            r_rspValid <= (w_nextState == RESP);
            if (r_state == RESP) begin
                r_txnCount <= r_txnCount + CNTW'(1);
            end
            if (r_state == IDLE && w_accept) begin
                if (w_isWrite) begin
                    r_idx    <= w_idx;
                    r_idxErr <= w_idxErr;
                end else begin
                    r_rspData <= w_rdData;
                    r_rspErr  <= w_idxErr;
                end
            end
            if (r_state == WDATA && w_accept) begin
                for (int r = 0; r < DEPTH; r++) begin
                    if (!r_idxErr && r_idx == IDXW'(r)) begin
                        r_bank[r] <= i_bus.word;
                    end
                end
                r_rspData <= i_bus.word;
                r_rspErr  <= r_idxErr;
            end
        end
    end

    assign i_bus.ready  = r_ready;
    assign o_rsp_valid  = r_rspValid;
    assign o_rsp_data   = r_rspData;
    assign o_rsp_err    = r_rspErr;
    assign o_txn_count  = r_txnCount;

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_bankFlat
            assign o_bank[g*WIDTH +: WIDTH] = r_bank[g];
        end
    endgenerate
endmodule

// File: tb/tb_interface_a_responder.sv
// Directed bench for interface_a_responder: transaction table plus hand-written
// back-to-back, mid-write reset and counter-wrap sequences.
module tb_interface_a_responder;
    localparam int WIDTH = 10;
    localparam int DEPTH = 10;
    localparam int CNTW  = 16;
    localparam int CNTW2 = 6;

    typedef struct {
        string      name;
        logic [9:0] cmd;
        logic [9:0] data;
        logic [9:0] expData;
        logic       expErr;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    interface_a_responder_if #(.WIDTH(WIDTH)) bus ();
    interface_a_responder_if #(.WIDTH(WIDTH)) bus2 ();

    logic                   o_rsp_valid;
    logic [WIDTH-1:0]       o_rsp_data;
    logic                   o_rsp_err;
    logic [DEPTH*WIDTH-1:0] o_bank;
    logic [CNTW-1:0]        o_txn_count;

    logic                   rspValid2;
    logic [WIDTH-1:0]       rspData2;
    logic                   rspErr2;
    logic [DEPTH*WIDTH-1:0] bank2;
    logic [CNTW2-1:0]       txnCount2;

    interface_a_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .i_clk       (clk),
        .i_rst       (rst_n),
        .i_bus       (bus),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_data  (o_rsp_data),
        .o_rsp_err   (o_rsp_err),
        .o_bank      (o_bank),
        .o_txn_count (o_txn_count)
    );

    // Narrow counter instance so the wrap is reachable in a short run
    interface_a_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW2)) dutWrap (
        .i_clk       (clk),
        .i_rst       (rst_n),
        .i_bus       (bus2),
        .o_rsp_valid (rspValid2),
        .o_rsp_data  (rspData2),
        .o_rsp_err   (rspErr2),
        .o_bank      (bank2),
        .o_txn_count (txnCount2)
    );

    int checks   = 0;
    int failures = 0;
    int expCount = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendWord(input logic [9:0] w, output bit ok);
        ok = 1'b0;
        bus.valid = 1'b1;
        bus.word  = w;
        for (int n = 0; n < 20; n++) begin
            if (bus.ready === 1'b1) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        bus.valid = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        bit ok;
        sendWord(v.cmd, ok);
        if (!ok) begin
            checkOutput({v.name, ".cmdAccept"}, 32'(ok), 1);
            return;
        end
        if (v.cmd[9]) begin
            checkOutput({v.name, ".wdataReady"}, 32'(bus.ready), 1);
            checkOutput({v.name, ".noEarlyRsp"}, 32'(o_rsp_valid), 0);
            sendWord(v.data, ok);
            if (!ok) begin
                checkOutput({v.name, ".dataAccept"}, 32'(ok), 1);
                return;
            end
        end
        checkOutput({v.name, ".rspValid"}, 32'(o_rsp_valid), 1);
        checkOutput({v.name, ".rspReady"}, 32'(bus.ready), 0);
        checkOutput({v.name, ".rspData"}, 32'(o_rsp_data), 32'(v.expData));
        checkOutput({v.name, ".rspErr"}, 32'(o_rsp_err), 32'(v.expErr));
        expCount++;
        tick();
        checkOutput({v.name, ".rspDrop"}, 32'(o_rsp_valid), 0);
        checkOutput({v.name, ".count"}, 32'(o_txn_count), 32'(expCount));
    endtask

    vec_t       vecs [13];
    logic [9:0] expBank [DEPTH];
    logic [9:0] words [4];
    logic [9:0] expB2b [3];

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit   ok;
        bit   acc;
        bit   found;
        int   ptr;
        int   rspCnt;

        vecs[0]  = '{"rd3",       10'h003, 10'h000, 10'h000, 1'b0};
        vecs[1]  = '{"wr3",       10'h203, 10'h2A5, 10'h2A5, 1'b0};
        vecs[2]  = '{"rd3new",    10'h003, 10'h000, 10'h2A5, 1'b0};
        vecs[3]  = '{"wr0",       10'h200, 10'h0C3, 10'h0C3, 1'b0};
        vecs[4]  = '{"wr12",      10'h20C, 10'h155, 10'h155, 1'b1};
        vecs[5]  = '{"rd15",      10'h00F, 10'h000, 10'h000, 1'b1};
        vecs[6]  = '{"wr9",       10'h209, 10'h3FF, 10'h3FF, 1'b0};
        vecs[7]  = '{"rd9",       10'h009, 10'h000, 10'h3FF, 1'b0};
        vecs[8]  = '{"wr10",      10'h20A, 10'h111, 10'h111, 1'b1};
        vecs[9]  = '{"rd10",      10'h00A, 10'h000, 10'h000, 1'b1};
        vecs[10] = '{"rd0",       10'h000, 10'h000, 10'h0C3, 1'b0};
        vecs[11] = '{"rd3ignBits",10'h1F3, 10'h000, 10'h2A5, 1'b0};
        vecs[12] = '{"wr5ignBits",10'h3F5, 10'h0AA, 10'h0AA, 1'b0};

        for (int r = 0; r < DEPTH; r++) expBank[r] = 10'h000;
        expBank[0] = 10'h0C3;
        expBank[3] = 10'h2A5;
        expBank[5] = 10'h0AA;
        expBank[9] = 10'h3FF;

        words  = '{10'h003, 10'h205, 10'h155, 10'h005};
        expB2b = '{10'h2A5, 10'h155, 10'h155};

        rst_n      = 1'b0;
        bus.valid  = 1'b0;
        bus.word   = '0;
        bus2.valid = 1'b0;
        bus2.word  = '0;
        repeat (3) tick();

        checkOutput("reset.ready", 32'(bus.ready), 0);
        checkOutput("reset.rspValid", 32'(o_rsp_valid), 0);
        checkOutput("reset.count", 32'(o_txn_count), 0);
        checkOutput("reset.bankZero", 32'(o_bank === '0), 1);

        rst_n = 1'b1;
        #1;
        checkOutput("release.readyLow", 32'(bus.ready), 0);
        tick();
        checkOutput("release.readyHigh", 32'(bus.ready), 1);

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
        end
        for (int r = 0; r < DEPTH; r++) begin
            checkOutput($sformatf("bank.row%0d", r), 32'(o_bank[r*WIDTH +: WIDTH]), 32'(expBank[r]));
        end

        // Back-to-back with valid held high: RESP cycles must refuse the waiting word
        ptr    = 0;
        rspCnt = 0;
        for (int n = 0; n < 40 && rspCnt < 3; n++) begin
            bus.valid = (ptr < 4);
            bus.word  = words[ptr < 4 ? ptr : 3];
            if (o_rsp_valid === 1'b1) begin
                checkOutput("b2b.readyInResp", 32'(bus.ready), 0);
                checkOutput($sformatf("b2b.data%0d", rspCnt), 32'(o_rsp_data), 32'(expB2b[rspCnt]));
                rspCnt++;
            end
            acc = bus.valid && (bus.ready === 1'b1);
            tick();
            if (acc) ptr++;
        end
        bus.valid = 1'b0;
        expCount += 3;
        checkOutput("b2b.responses", 32'(rspCnt), 3);
        checkOutput("b2b.consumed", 32'(ptr), 4);
        checkOutput("b2b.noExtraRsp", 32'(o_rsp_valid), 0);
        checkOutput("b2b.count", 32'(o_txn_count), 32'(expCount));
        checkOutput("b2b.row5", 32'(o_bank[5*WIDTH +: WIDTH]), 32'h155);

        // Reset lands between the command and data beats of a write
        sendWord(10'h204, ok);
        checkOutput("midRst.cmdAccept", 32'(ok), 1);
        rst_n = 1'b0;
        #2;
        checkOutput("midRst.readyLow", 32'(bus.ready), 0);
        checkOutput("midRst.bankClear", 32'(o_bank === '0), 1);
        checkOutput("midRst.countClear", 32'(o_txn_count), 0);
        for (int n = 0; n < 3; n++) begin
            tick();
            checkOutput("midRst.noRsp", 32'(o_rsp_valid), 0);
        end
        rst_n    = 1'b1;
        expCount = 0;
        tick();
        checkOutput("midRst.readyAfter", 32'(bus.ready), 1);
        applyStimulus('{"postRstCmd", 10'h007, 10'h000, 10'h000, 1'b0});
        checkOutput("midRst.row4", 32'(o_bank[4*WIDTH +: WIDTH]), 0);

        // Counter wrap on the narrow instance
        bus2.word  = 10'h000;
        bus2.valid = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (txnCount2 === 6'd63) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checkOutput("wrap.reach63", 32'(found), 1);
        found = 1'b0;
        for (int n = 0; n < 5; n++) begin
            if (rspValid2 === 1'b1) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checkOutput("wrap.pulse", 32'(found), 1);
        tick();
        checkOutput("wrap.countZero", 32'(txnCount2), 0);
        bus2.valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
